// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - pipelined quadrant approximate multiplier with runtime approximation control
//
// Purpose: splits each W-bit operand into H=W/2 halves, forms the four HxH
// sub-products, truncates each by its own level, then sums them with either
// an exact adder or an adder whose low ADD_CUT bits are combined by OR.
// Every result is compared against the exact product; mismatches delivered
// downstream are tallied in a saturating counter.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    operand stream handshake (in_ready = pipeline enable)
//   in_a, in_b           unsigned operands
//   in_lvl               quadrant levels {HH,HL,LH,LL}, HH in the MSBs
//   in_add_ex            1 = exact final adder, 0 = OR-low-bits adder
//   out_valid/out_ready  result stream handshake
//   out_prod             approximate product
//   out_err              out_prod differs from the exact product
//   err_cnt              saturating count of delivered results with out_err=1
//   cnt_clr              synchronous clear of err_cnt (wins over increment)
module approx_mul_pipe #(
    parameter int W       = 8,
    parameter int ADD_CUT = 8,
    parameter int CNTW    = 16,
    localparam int H      = W / 2,
    localparam int LVLW   = $clog2(H + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [4*LVLW-1:0] in_lvl,
    input  logic              in_add_ex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_prod,
    output logic              out_err,
    output logic [CNTW-1:0]   err_cnt,
    input  logic              cnt_clr
);

    // Bits at or above ADD_CUT take part in the carry-propagating sum in
    // inexact mode; shifting by the full width yields 0, so ADD_CUT=2W
    // turns the whole result into an OR.
    localparam logic [2*W-1:0] HI_MASK = {(2*W){1'b1}} << ADD_CUT;

    // One enable for the whole pipe: a stalled output freezes every stage,
    // bubbles included.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Clamp the level to H and clear that many low bits of a sub-product.
    function automatic logic [2*H-1:0] trim(input logic [2*H-1:0] p,
                                            input logic [LVLW-1:0] l);
        logic [LVLW-1:0] lc;
        lc = (l > LVLW'(H)) ? LVLW'(H) : l;
        return p & ({(2*H){1'b1}} << lc);
    endfunction

    // Stage 1: operands and control
    logic              s1_v;
    logic [W-1:0]      s1_a, s1_b;
    logic [4*LVLW-1:0] s1_lvl;
    logic              s1_ex;

    // Stage 2: aligned, truncated partial products
    logic              s2_v;
    logic [2*W-1:0]    s2_phh, s2_phl, s2_plh, s2_pll;
    logic [W-1:0]      s2_a, s2_b;
    logic              s2_ex;

    logic [H-1:0]   ah, al, bh, bl;
    logic [2*H-1:0] hh, hl, lh, ll;

    assign ah = s1_a[W-1:H];
    assign al = s1_a[H-1:0];
    assign bh = s1_b[W-1:H];
    assign bl = s1_b[H-1:0];

    assign hh = trim((2*H)'(ah) * (2*H)'(bh), s1_lvl[4*LVLW-1:3*LVLW]);
    assign hl = trim((2*H)'(ah) * (2*H)'(bl), s1_lvl[3*LVLW-1:2*LVLW]);
    assign lh = trim((2*H)'(al) * (2*H)'(bh), s1_lvl[2*LVLW-1:LVLW]);
    assign ll = trim((2*H)'(al) * (2*H)'(bl), s1_lvl[LVLW-1:0]);

    // Stage 3 combinational: final adder and exact reference
    logic [2*W-1:0] sum_ex, sum_hi, or_lo, prod, exact;

    assign sum_ex = s2_phh + s2_phl + s2_plh + s2_pll;
    // High-part addends have zero low bits, so no carry can come up from
    // the OR-combined region.
    assign sum_hi = (s2_phh & HI_MASK) + (s2_phl & HI_MASK)
                  + (s2_plh & HI_MASK) + (s2_pll & HI_MASK);
    assign or_lo  = (s2_phh | s2_phl | s2_plh | s2_pll) & ~HI_MASK;
    assign prod   = s2_ex ? sum_ex : (sum_hi | or_lo);
    assign exact  = (2*W)'(s2_a) * (2*W)'(s2_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_lvl    <= '0;
            s1_ex     <= 1'b0;
            s2_v      <= 1'b0;
            s2_phh    <= '0;
            s2_phl    <= '0;
            s2_plh    <= '0;
            s2_pll    <= '0;
            s2_a      <= '0;
            s2_b      <= '0;
            s2_ex     <= 1'b0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_err   <= 1'b0;
        end else if (en) begin
            s1_v      <= in_valid;
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_lvl    <= in_lvl;
            s1_ex     <= in_add_ex;
            s2_v      <= s1_v;
            s2_phh    <= {hh, W'(0)};
            s2_phl    <= (2*W)'(hl) << H;
            s2_plh    <= (2*W)'(lh) << H;
            s2_pll    <= (2*W)'(ll);
            s2_a      <= s1_a;
            s2_b      <= s1_b;
            s2_ex     <= s1_ex;
            out_valid <= s2_v;
            out_prod  <= prod;
            out_err   <= (prod != exact);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != {CNTW{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
